shift_window: RTL and testbench

Multi-channel, parametrised tap window for the convolution datapath. It holds N taps of C channels × B bits each (for example, RGB pixels along one kernel axis) and presents all taps in parallel to the multiply-accumulate stage. It supports four shift modes (up, down, centre-inward, rotate), a synchronous clear, and a fill counter with a `full` flag, so that downstream logic knows when the window contents are valid.

---
 rtl/shift_window_pkg.sv | 32 +++
 rtl/shift_window_lane.sv | 67 ++++++
 rtl/shift_window.sv | 97 +++++++++
 tb/tb_shift_window.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_window_pkg.sv
// ============================================================================
// Module      : shift_window_pkg
// Description : Shared types and helpers for the shift_window tap window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_window_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_CENTER = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    // Size of the up half in centre mode; the odd middle tap belongs to it.
    function automatic int half_up(input int n);
        return (n + 1) / 2;
    endfunction

    // Saturating fill increment. The sum is formed in a 32-bit int, which is
    // wider than the counter, so the addition cannot wrap before the clamp.
    function automatic int fill_sat(input int cnt, input int inc, input int lim);
        int sum;
        sum = cnt + inc;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_window_lane.sv
// ============================================================================
// Module      : shift_window_lane
// Description : One channel's N x B tap chain with up/down/centre/rotate
//               shifting, synchronous clear and a load-all path used for
//               border replication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_window_lane
    import shift_window_pkg::*;
#(
    parameter int N = 11,
    parameter int B = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  mode_e               i_mode,
    input  logic                i_load_all,
    input  logic [B-1:0]        i_din,
    output logic [N-1:0][B-1:0] o_taps
);

    localparam int c_N2 = half_up(N);

    logic [N-1:0][B-1:0] r_taps;

    // Tap chain update: clear beats shift, shift beats hold.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_taps <= '0;
        end else if (i_en) begin
            if (i_load_all) begin
                for (int i = 0; i < N; i++) r_taps[i] <= i_din;
            end else begin
                case (i_mode)
                    MODE_UP: begin
                        r_taps[0] <= i_din;
                        for (int i = 1; i < N; i++) r_taps[i] <= r_taps[i-1];
                    end
                    MODE_DOWN: begin
                        r_taps[N-1] <= i_din;
                        for (int i = 0; i < N - 1; i++) r_taps[i] <= r_taps[i+1];
                    end
                    MODE_CENTER: begin
                        // Two independent halves; tap N2-1 never reads tap N2.
                        r_taps[0]   <= i_din;
                        for (int i = 1; i < c_N2; i++) r_taps[i] <= r_taps[i-1];
                        r_taps[N-1] <= i_din;
                        for (int i = c_N2; i < N - 1; i++) r_taps[i] <= r_taps[i+1];
                    end
                    default: begin
                        r_taps[0] <= r_taps[N-1];
                        for (int i = 1; i < N; i++) r_taps[i] <= r_taps[i-1];
                    end
                endcase
            end
        end
    end

    assign o_taps = r_taps;

endmodule

`default_nettype wire

// File: rtl/shift_window.sv
// ============================================================================
// Module      : shift_window
// Description : Multi-channel N-tap window for the convolution datapath.
//               Owns the fill counter, the full flag and the border
//               replication control; C lanes hold the tap data.
//               Optional feature macro: SHIFT_WINDOW_REPLICATE_EN
//               (first write after clear loads din into every tap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_window
    import shift_window_pkg::*;
#(
    parameter int N = 11,
    parameter int B = 8,
    parameter int C = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         clr,
    input  logic [C-1:0][B-1:0]          din,
    output logic [N-1:0][C-1:0][B-1:0]   dout,
    output logic [$clog2(N+1)-1:0]       fill_cnt,
    output logic                         full
);

    localparam int c_FW = $clog2(N + 1);

    mode_e                        w_mode;
    int                           w_inc;
    logic [c_FW-1:0]              w_fill_next;
    logic                         w_load_all;
    logic [c_FW-1:0]              r_fill;
    logic [C-1:0][N-1:0][B-1:0]   w_lane_taps;

    assign w_mode = mode_e'(mode);

    // Number of taps a shift newly writes: centre writes both ends.
    always_comb begin
        w_inc = 0;
        case (w_mode)
            MODE_UP:     w_inc = 1;
            MODE_DOWN:   w_inc = 1;
            MODE_CENTER: w_inc = 2;
            default:     w_inc = 0;
        endcase
    end

    assign w_fill_next = c_FW'(fill_sat(int'(r_fill), w_inc, N));

`ifdef SHIFT_WINDOW_REPLICATE_EN
    // Empty window: replicate the first sample across every tap.
    assign w_load_all = en && (r_fill == '0) && (w_mode != MODE_ROTATE);
`else
    assign w_load_all = 1'b0;
`endif

    // Fill counter: counts taps written since the last clear, saturating at N.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_fill <= '0;
        end else if (en) begin
            if (w_load_all) r_fill <= c_FW'(N);
            else            r_fill <= w_fill_next;
        end
    end

    assign fill_cnt = r_fill;
    assign full     = (r_fill == c_FW'(N));

    generate
        for (genvar c = 0; c < C; c++) begin : g_lane
            shift_window_lane #(
                .N (N),
                .B (B)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (clr),
                .i_en       (en),
                .i_mode     (w_mode),
                .i_load_all (w_load_all),
                .i_din      (din[c]),
                .o_taps     (w_lane_taps[c])
            );
            for (genvar i = 0; i < N; i++) begin : g_tap
                assign dout[i][c] = w_lane_taps[c][i];
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_shift_window.sv
// ============================================================================
// Module      : tb_shift_window
// Description : Self-checking bench for shift_window (N=5, B=8, C=2) with
//               directed scenarios and a random run against a list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_window;

    localparam int N = 5;
    localparam int B = 8;
    localparam int C = 2;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         en = 1'b0;
    logic [1:0]                   mode = 2'b00;
    logic                         clr = 1'b0;
    logic [C-1:0][B-1:0]          din = '0;
    logic [N-1:0][C-1:0][B-1:0]   dout;
    logic [2:0]                   fill_cnt;
    logic                         full;

    int total = 0;
    int bad   = 0;

    // Reference: tap values per channel and the fill count.
    logic [7:0] m_tap [N][C];
    int         m_fill = 0;

    shift_window #(.N(N), .B(B), .C(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .clr      (clr),
        .din      (din),
        .dout     (dout),
        .fill_cnt (fill_cnt),
        .full     (full)
    );

    always #5 clk = ~clk;

    // Reference update from the behavioural rules, treating the window as a list.
    task automatic model_step(input bit e, input bit [1:0] md, input bit c, input logic [7:0] d0);
        logic [7:0] nt [N][C];
        logic [7:0] d;
        int h;
        h = (N + 1) / 2;
        if (c) begin
            for (int i = 0; i < N; i++) for (int k = 0; k < C; k++) m_tap[i][k] = 8'h00;
            m_fill = 0;
            return;
        end
        if (!e) return;
`ifdef SHIFT_WINDOW_REPLICATE_EN
        if (m_fill == 0 && md != 2'b11) begin
            for (int k = 0; k < C; k++) begin
                d = d0 + 8'(k * 8'h80);
                for (int i = 0; i < N; i++) m_tap[i][k] = d;
            end
            m_fill = N;
            return;
        end
`endif
        for (int k = 0; k < C; k++) begin
            d = d0 + 8'(k * 8'h80);
            for (int i = 0; i < N; i++) nt[i][k] = m_tap[i][k];
            case (md)
                2'b00: begin nt[0][k] = d; for (int i = 1; i < N; i++) nt[i][k] = m_tap[i-1][k]; end
                2'b01: begin nt[N-1][k] = d; for (int i = 0; i < N-1; i++) nt[i][k] = m_tap[i+1][k]; end
                2'b10: begin
                    nt[0][k] = d;
                    for (int i = 1; i < h; i++) nt[i][k] = m_tap[i-1][k];
                    nt[N-1][k] = d;
                    for (int i = h; i < N-1; i++) nt[i][k] = m_tap[i+1][k];
                end
                default: begin nt[0][k] = m_tap[N-1][k]; for (int i = 1; i < N; i++) nt[i][k] = m_tap[i-1][k]; end
            endcase
            for (int i = 0; i < N; i++) m_tap[i][k] = nt[i][k];
        end
        if (md == 2'b00 || md == 2'b01) m_fill = (m_fill + 1 > N) ? N : m_fill + 1;
        else if (md == 2'b10)           m_fill = (m_fill + 2 > N) ? N : m_fill + 2;
    endtask

    // One clock with the given controls; ch1 carries ch0 + 0x80.
    task automatic drive(input bit e, input bit [1:0] md, input bit c, input logic [7:0] d0);
        en = e; mode = md; clr = c;
        din[0] = d0; din[1] = d0 + 8'h80;
        @(posedge clk); #1;
        model_step(e, md, c, d0);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b00; clr = 1'b0; din[0] = 8'hAA; din[1] = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0;
        model_step(1'b0, 2'b00, 1'b1, 8'h00);
        for (int i = 0; i < N; i++) for (int k = 0; k < C; k++) begin
            total++;
            if (dout[i][k] !== 8'h00) begin bad++; $display("FAIL reset_tap%0d_ch%0d got %h want 00", i, k, dout[i][k]); end
        end
        total++;
        if (fill_cnt !== 3'd0) begin bad++; $display("FAIL reset_fill got %0d want 0", fill_cnt); end
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", full); end
    endtask

    task automatic test_up();
        logic [7:0] exp0 [N];
        exp0 = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        drive(1'b0, 2'b00, 1'b1, 8'h00);
        for (int s = 1; s <= 5; s++) begin
            drive(1'b1, 2'b00, 1'b0, 8'(s));
`ifndef SHIFT_WINDOW_REPLICATE_EN
            total++;
            if (fill_cnt !== 3'(s)) begin bad++; $display("FAIL up_fill_step%0d got %0d want %0d", s, fill_cnt, s); end
            total++;
            if (full !== (s == 5)) begin bad++; $display("FAIL up_full_step%0d got %b want %b", s, full, s == 5); end
`endif
        end
`ifndef SHIFT_WINDOW_REPLICATE_EN
        for (int i = 0; i < N; i++) begin
            total++;
            if (dout[i][0] !== exp0[i]) begin bad++; $display("FAIL up_tap%0d_ch0 got %h want %h", i, dout[i][0], exp0[i]); end
            total++;
            if (dout[i][1] !== exp0[i] + 8'h80) begin bad++; $display("FAIL up_tap%0d_ch1 got %h want %h", i, dout[i][1], exp0[i] + 8'h80); end
        end
`endif
        drive(1'b1, 2'b00, 1'b0, 8'd6);
        total++;
        if (fill_cnt !== 3'd5) begin bad++; $display("FAIL up_sat_fill got %0d want 5", fill_cnt); end
    endtask

    task automatic test_down();
        logic [7:0] snap [N];
        drive(1'b0, 2'b00, 1'b1, 8'h00);
        for (int s = 1; s <= 5; s++) drive(1'b1, 2'b01, 1'b0, 8'(s));
`ifndef SHIFT_WINDOW_REPLICATE_EN
        for (int i = 0; i < N; i++) begin
            total++;
            if (dout[i][0] !== 8'(i + 1)) begin bad++; $display("FAIL down_tap%0d got %h want %h", i, dout[i][0], 8'(i + 1)); end
        end
`endif
        for (int i = 0; i < N; i++) snap[i] = m_tap[i][0];
        for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), 1'b0, 8'hEE);
        for (int i = 0; i < N; i++) begin
            total++;
            if (dout[i][0] !== snap[i]) begin bad++; $display("FAIL idle_tap%0d got %h want %h", i, dout[i][0], snap[i]); end
        end
        total++;
        if (fill_cnt !== 3'd5) begin bad++; $display("FAIL idle_fill got %0d want 5", fill_cnt); end
    endtask

    task automatic test_centre();
        logic [7:0] exp0 [N];
        int         expf [3];
        exp0 = '{8'd30, 8'd20, 8'd10, 8'd20, 8'd30};
        expf = '{2, 4, 5};
        drive(1'b0, 2'b00, 1'b1, 8'h00);
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 2'b10, 1'b0, 8'((s + 1) * 10));
`ifndef SHIFT_WINDOW_REPLICATE_EN
            total++;
            if (fill_cnt !== 3'(expf[s])) begin bad++; $display("FAIL centre_fill_step%0d got %0d want %0d", s, fill_cnt, expf[s]); end
`endif
        end
`ifndef SHIFT_WINDOW_REPLICATE_EN
        for (int i = 0; i < N; i++) begin
            total++;
            if (dout[i][0] !== exp0[i]) begin bad++; $display("FAIL centre_tap%0d got %h want %h", i, dout[i][0], exp0[i]); end
        end
`endif
    endtask

    task automatic test_rotate_clr();
        logic [7:0] exp0 [N];
        exp0 = '{8'd5, 8'd1, 8'd2, 8'd3, 8'd4};
        drive(1'b0, 2'b00, 1'b1, 8'h00);
        for (int s = 5; s >= 1; s--) drive(1'b1, 2'b00, 1'b0, 8'(s));
        drive(1'b1, 2'b11, 1'b0, 8'hCC);
`ifndef SHIFT_WINDOW_REPLICATE_EN
        for (int i = 0; i < N; i++) begin
            total++;
            if (dout[i][0] !== exp0[i]) begin bad++; $display("FAIL rotate_tap%0d got %h want %h", i, dout[i][0], exp0[i]); end
        end
`endif
        total++;
        if (fill_cnt !== 3'd5) begin bad++; $display("FAIL rotate_fill got %0d want 5", fill_cnt); end
        drive(1'b1, 2'b00, 1'b1, 8'h33);
        for (int i = 0; i < N; i++) for (int k = 0; k < C; k++) begin
            total++;
            if (dout[i][k] !== 8'h00) begin bad++; $display("FAIL clr_tap%0d_ch%0d got %h want 00", i, k, dout[i][k]); end
        end
        total++;
        if (fill_cnt !== 3'd0) begin bad++; $display("FAIL clr_fill got %0d want 0", fill_cnt); end
    endtask

    task automatic test_replicate();
        drive(1'b0, 2'b00, 1'b1, 8'h00);
        drive(1'b1, 2'b00, 1'b0, 8'h7F);
        for (int i = 0; i < N; i++) begin
`ifdef SHIFT_WINDOW_REPLICATE_EN
            total++;
            if (dout[i][0] !== 8'h7F) begin bad++; $display("FAIL repl_tap%0d got %h want 7f", i, dout[i][0]); end
`else
            total++;
            if (dout[i][0] !== ((i == 0) ? 8'h7F : 8'h00)) begin bad++; $display("FAIL repl_tap%0d got %h want %h", i, dout[i][0], (i == 0) ? 8'h7F : 8'h00); end
`endif
        end
`ifdef SHIFT_WINDOW_REPLICATE_EN
        total++;
        if (full !== 1'b1 || fill_cnt !== 3'd5) begin bad++; $display("FAIL repl_full got full=%b fill=%0d want full=1 fill=5", full, fill_cnt); end
`else
        total++;
        if (full !== 1'b0 || fill_cnt !== 3'd1) begin bad++; $display("FAIL repl_full got full=%b fill=%0d want full=0 fill=1", full, fill_cnt); end
`endif
    endtask

    task automatic test_random();
        bit         e, c;
        bit [1:0]   md;
        logic [7:0] d;
        for (int n = 0; n < 300; n++) begin
            e  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 15) == 0);
            md = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            drive(e, md, c, d);
            for (int i = 0; i < N; i++) for (int k = 0; k < C; k++) begin
                total++;
                if (dout[i][k] !== m_tap[i][k]) begin bad++; $display("FAIL rand%0d_tap%0d_ch%0d got %h want %h", n, i, k, dout[i][k], m_tap[i][k]); end
            end
            total++;
            if (fill_cnt !== 3'(m_fill) || full !== (m_fill == N)) begin
                bad++; $display("FAIL rand%0d_fill got fill=%0d full=%b want fill=%0d full=%b", n, fill_cnt, full, m_fill, m_fill == N);
            end
        end
    endtask

    task automatic test_midstream_rst();
        drive(1'b1, 2'b00, 1'b0, 8'h11);
        drive(1'b1, 2'b10, 1'b0, 8'h22);
        rst = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 8'h44);
        rst = 1'b0;
        model_step(1'b0, 2'b00, 1'b1, 8'h00);
        for (int i = 0; i < N; i++) for (int k = 0; k < C; k++) begin
            total++;
            if (dout[i][k] !== 8'h00) begin bad++; $display("FAIL midrst_tap%0d_ch%0d got %h want 00", i, k, dout[i][k]); end
        end
        total++;
        if (fill_cnt !== 3'd0 || full !== 1'b0) begin bad++; $display("FAIL midrst_fill got fill=%0d full=%b want 0 0", fill_cnt, full); end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_centre();
        test_rotate_clr();
        test_replicate();
        test_random();
        test_midstream_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
